maf_t4_add: RTL and testbench
=============================

# maf_t4_add

Stage T4 of the MAF datapath: consumes the registered carry-save product, aligned addend and side-band fields produced by the T3_2 pipeline register. It merges them into a signed 74-bit magnitude with end-around-carry handling for effective subtraction. Results go to the normalisation stage behind a one-cycle output register with a single-entry skid buffer, so that downstream stalls never drop a beat.

## Interface
Parameters:
- none (all widths fixed by the MAF datapath)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  T3_2 beat valid
- in_ready  out  1  stage can accept a beat this cycle
- Carry_in  in  48  carry vector of product
- Sum_in  in  48  sum vector of product
- sh_rev_reg_in  in  74  aligned addend
- S_A, S_B, S_C  in  1 each  operand signs; product sign Sp = S_A^S_B
- S_A_H, S_B_H, S_C_H  in  1 each  high-half signs, passed through
- cont_in  in  3  control, passed through
- d_in  in  12  alignment distance, passed through
- E_in  in  12  tentative exponent, passed through
- sti  in  4  sticky bits, passed through
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- mag_out  out  74  result magnitude
- sign_out  out  1  result sign
- zero_out  out  1  mag_out == 0
- S_A_H_out, S_B_H_out, S_C_H_out, cont_out, d_out, E_out, sti_out  out  as inputs  registered pass-through
- lzc_out  out  7  leading-zero count of mag_out (only with MAF_T4_LZC_EN)

## Operation
- eff_sub = S_A ^ S_B ^ S_C.
- A = eff_sub ? ~sh_rev_reg_in : sh_rev_reg_in (74 bits).
- T[74:0] = A + zext(Carry_in) + zext(Sum_in), computed 75 bits wide with no carry-in.
- !eff_sub: mag = T[73:0], sign = Sp. T[74] is guaranteed 0 by upstream alignment and is ignored.
- eff_sub && T[74]: mag = T[73:0] + 1 (end-around carry), sign = Sp.
- eff_sub && !T[74]: mag = ~T[73:0], sign = S_C.
- mag == 0: sign forced 0, zero_out = 1.
- sti does not enter the arithmetic; it is carried for the rounding stage.
- Buffering: output register OR plus skid register SK, each with a valid bit.
  - Accept when in_valid && in_ready.
  - OR empty or draining (out_ready): the accepted beat, or the SK beat if SK is full, loads OR. SK has priority, which preserves order.
  - OR full and stalled: the accepted beat loads SK.
  - in_ready = !SK_valid && !rst.
- States: EMPTY (neither valid), ONE (OR valid), TWO (OR and SK valid). TWO is reachable only via a stall while accepting in ONE.

## Timing
- Latency: 1 cycle from acceptance to out_valid when unstalled.
- Throughput: 1 beat per cycle with out_ready held high.
- Reset: out_valid = 0, SK_valid = 0, in_ready = 0 during the reset cycle, and every data output = 0 (mag_out, sign_out, zero_out = 0, lzc_out = 0, pass-throughs = 0).
- Reset mid-operation: both beats are discarded and no partial output is presented. in_ready = 1 on the first cycle after rst falls.
- out_* are stable while out_valid && !out_ready.
- Simultaneous accept and drain in ONE: OR is reloaded, state stays ONE.
- Drain without accept in TWO: SK moves to OR, state goes to ONE, and in_ready rises the next cycle.

## Configuration
- MAF_T4_LZC_EN defined: a 74-bit leading-zero counter is computed on mag before the output register and is registered with the beat. lzc_out gives 0..74; mag == 0 gives 74. SK also stores lzc.
- Not defined: lzc_out is absent from the port list and no counter logic is generated.

## Test plan
- Add path: Carry=0x1, Sum=0x2, sh_rev=0x4, all signs 0, out_ready=1 -> next cycle out_valid=1, mag=0x7, sign=0, zero=0.
- Eff-sub, product larger: S_C=1, Carry=0, Sum=5, sh_rev=3 -> mag=2, sign=0 (end-around carry taken).
- Eff-sub, addend larger: S_C=1, Sum=3, sh_rev=5 -> mag=2, sign=1.
- Exact cancellation: S_C=1, Sum=5, sh_rev=5 -> mag=0, zero=1, sign=0. With LZC enabled, lzc_out=74.
- Backpressure: stream beats E_in=1,2,3 with out_ready=0 for 3 cycles -> in_ready drops after beat 2. On release, outputs appear in order 1,2,3 with no loss or duplication.
- Reset with TWO occupied: assert rst for one cycle -> out_valid=0 and all outputs 0 that cycle; in_ready=1 the following cycle.

Source files
------------

// File: rtl/maf_t4_add_if.sv
// MAF T4 handshake bundles: T3_2 beat in, normalisation beat out.
// lzc_out exists only when MAF_T4_LZC_EN is defined.
interface maf_t4_in_if;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] Carry_in;
  logic [47:0] Sum_in;
  logic [73:0] sh_rev_reg_in;
  logic        S_A, S_B, S_C;
  logic        S_A_H, S_B_H, S_C_H;
  logic [2:0]  cont_in;
  logic [11:0] d_in;
  logic [11:0] E_in;
  logic [3:0]  sti;

  modport master (
    output in_valid, Carry_in, Sum_in, sh_rev_reg_in,
    output S_A, S_B, S_C, S_A_H, S_B_H, S_C_H,
    output cont_in, d_in, E_in, sti,
    input  in_ready
  );
  modport slave (
    input  in_valid, Carry_in, Sum_in, sh_rev_reg_in,
    input  S_A, S_B, S_C, S_A_H, S_B_H, S_C_H,
    input  cont_in, d_in, E_in, sti,
    output in_ready
  );
endinterface

interface maf_t4_out_if;
  logic        out_valid;
  logic        out_ready;
  logic [73:0] mag_out;
  logic        sign_out;
  logic        zero_out;
  logic        S_A_H_out, S_B_H_out, S_C_H_out;
  logic [2:0]  cont_out;
  logic [11:0] d_out;
  logic [11:0] E_out;
  logic [3:0]  sti_out;
`ifdef MAF_T4_LZC_EN
  logic [6:0]  lzc_out;
`endif

  modport master (
    output out_valid, mag_out, sign_out, zero_out,
    output S_A_H_out, S_B_H_out, S_C_H_out,
    output cont_out, d_out, E_out, sti_out,
`ifdef MAF_T4_LZC_EN
    output lzc_out,
`endif
    input  out_ready
  );
  modport slave (
    input  out_valid, mag_out, sign_out, zero_out,
    input  S_A_H_out, S_B_H_out, S_C_H_out,
    input  cont_out, d_out, E_out, sti_out,
`ifdef MAF_T4_LZC_EN
    input  lzc_out,
`endif
    output out_ready
  );
endinterface

// File: rtl/maf_t4_add.sv
// MAF T4: carry-save merge with end-around carry, output reg + skid.
// Optional leading-zero count on the result: define MAF_T4_LZC_EN.
module maf_t4_add (
  input logic clk,
  input logic rst,
  maf_t4_in_if.slave   ib,
  maf_t4_out_if.master ob
);

  typedef struct packed {
    logic [73:0] mag;
    logic        sign;
    logic        zero;
    logic        sah;
    logic        sbh;
    logic        sch;
    logic [2:0]  cont;
    logic [11:0] d;
    logic [11:0] e;
    logic [3:0]  sti;
`ifdef MAF_T4_LZC_EN
    logic [6:0]  lzc;
`endif
  } res_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} st_t;

  st_t         st, st_n;
  res_t        res, or_q, sk_q, ov;
  logic        sp, eff_sub, sgn;
  logic [73:0] a, mag;
  logic [74:0] t;
  logic        rdy, acc;
  logic        ld_or, ld_sk, or_from_sk;

`ifdef MAF_T4_LZC_EN
  function automatic logic [6:0] lzc74(input logic [73:0] v);
    logic [6:0] n;
    logic       hit;
    n   = 7'd0;
    hit = 1'b0;
    for (int i = 73; i >= 0; i--) begin
      if (!hit) begin
        if (v[i]) hit = 1'b1;
        else      n = n + 7'd1;
      end
    end
    return n;
  endfunction
`endif

  assign sp      = ib.S_A ^ ib.S_B;
  assign eff_sub = sp ^ ib.S_C;
  assign a       = eff_sub ? ~ib.sh_rev_reg_in
                           : ib.sh_rev_reg_in;
  assign t       = {1'b0, a}
                 + {27'd0, ib.Carry_in}
                 + {27'd0, ib.Sum_in};

  // t[74] under subtraction means product > addend
  always_comb begin
    mag = t[73:0];
    sgn = sp;
    unique case (1'b1)
      !eff_sub: begin
        mag = t[73:0];
        sgn = sp;
      end
      (eff_sub && t[74]): begin
        mag = t[73:0] + 74'd1;
        sgn = sp;
      end
      (eff_sub && !t[74]): begin
        mag = ~t[73:0];
        sgn = ib.S_C;
      end
      default: ;
    endcase
  end

  always_comb begin
    res      = '0;
    res.mag  = mag;
    res.zero = (mag == 74'd0);
    res.sign = sgn && (mag != 74'd0);
    res.sah  = ib.S_A_H;
    res.sbh  = ib.S_B_H;
    res.sch  = ib.S_C_H;
    res.cont = ib.cont_in;
    res.d    = ib.d_in;
    res.e    = ib.E_in;
    res.sti  = ib.sti;
`ifdef MAF_T4_LZC_EN
    res.lzc  = lzc74(mag);
`endif
  end

  assign rdy         = (st != TWO) && !rst;
  assign acc         = ib.in_valid && rdy;
  assign ib.in_ready = rdy;

  always_ff @(posedge clk) begin
    if (rst) st <= EMPTY;
    else     st <= st_n;
  end

  always_comb begin
    st_n       = st;
    ld_or      = 1'b0;
    ld_sk      = 1'b0;
    or_from_sk = 1'b0;
    unique case (st)
      EMPTY: begin
        if (acc) begin
          ld_or = 1'b1;
          st_n  = ONE;
        end
      end
      ONE: begin
        if (ob.out_ready) begin
          if (acc) ld_or = 1'b1;
          else     st_n  = EMPTY;
        end else if (acc) begin
          ld_sk = 1'b1;
          st_n  = TWO;
        end
      end
      TWO: begin
        if (ob.out_ready) begin
          ld_or      = 1'b1;
          or_from_sk = 1'b1;
          st_n       = ONE;
        end
      end
      default: st_n = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      or_q <= '0;
      sk_q <= '0;
    end else begin
      if (ld_or) or_q <= or_from_sk ? sk_q : res;
      if (ld_sk) sk_q <= res;
    end
  end

  // outputs read as zero throughout the reset cycle
  assign ov           = rst ? '0 : or_q;
  assign ob.out_valid = (st != EMPTY) && !rst;
  assign ob.mag_out   = ov.mag;
  assign ob.sign_out  = ov.sign;
  assign ob.zero_out  = ov.zero;
  assign ob.S_A_H_out = ov.sah;
  assign ob.S_B_H_out = ov.sbh;
  assign ob.S_C_H_out = ov.sch;
  assign ob.cont_out  = ov.cont;
  assign ob.d_out     = ov.d;
  assign ob.E_out     = ov.e;
  assign ob.sti_out   = ov.sti;
`ifdef MAF_T4_LZC_EN
  assign ob.lzc_out   = ov.lzc;
`endif

endmodule

// File: tb/tb_maf_t4_add.sv
// Bench for maf_t4_add: reference model queue plus directed vectors.
// Builds with or without MAF_T4_LZC_EN.
module tb_maf_t4_add;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  maf_t4_in_if  ib();
  maf_t4_out_if ob();

  maf_t4_add dut (
    .clk (clk),
    .rst (rst),
    .ib  (ib),
    .ob  (ob)
  );

  typedef struct packed {
    logic [47:0] carry;
    logic [47:0] sum;
    logic [73:0] shr;
    logic        sa, sb, sc;
    logic        sah, sbh, sch;
    logic [2:0]  cont;
    logic [11:0] d;
    logic [11:0] e;
    logic [3:0]  sti;
  } beat_t;

  typedef struct packed {
    logic [73:0] mag;
    logic        sign;
    logic        zero;
    logic        sah, sbh, sch;
    logic [2:0]  cont;
    logic [11:0] d;
    logic [11:0] e;
    logic [3:0]  sti;
    logic [6:0]  lzc;
  } exp_t;

  int errors = 0;
  int checks = 0;
  exp_t        q[$];
  logic [11:0] elog[$];

  task automatic chk(input string name,
                     input logic [127:0] got,
                     input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // signed-magnitude result of (+/-)product (+/-)addend
  function automatic exp_t model(input beat_t b);
    exp_t        r;
    logic [74:0] p, a, s;
    logic        sp;
    r  = '0;
    p  = 75'(b.carry) + 75'(b.sum);
    a  = 75'(b.shr);
    sp = b.sa ^ b.sb;
    if (sp ^ b.sc) begin
      if (p > a) begin
        s = p - a;
        r.sign = sp;
      end else begin
        s = a - p;
        r.sign = b.sc;
      end
    end else begin
      s = a + p;
      r.sign = sp;
    end
    r.mag  = s[73:0];
    r.zero = (r.mag == 74'd0);
    if (r.zero) r.sign = 1'b0;
    r.sah  = b.sah;
    r.sbh  = b.sbh;
    r.sch  = b.sch;
    r.cont = b.cont;
    r.d    = b.d;
    r.e    = b.e;
    r.sti  = b.sti;
`ifdef MAF_T4_LZC_EN
    r.lzc = 7'd74;
    for (int i = 0; i < 74; i++)
      if (r.mag[i]) r.lzc = 7'(73 - i);
`endif
    return r;
  endfunction

  function automatic beat_t from_bus();
    beat_t b;
    b.carry = ib.Carry_in;
    b.sum   = ib.Sum_in;
    b.shr   = ib.sh_rev_reg_in;
    b.sa    = ib.S_A;
    b.sb    = ib.S_B;
    b.sc    = ib.S_C;
    b.sah   = ib.S_A_H;
    b.sbh   = ib.S_B_H;
    b.sch   = ib.S_C_H;
    b.cont  = ib.cont_in;
    b.d     = ib.d_in;
    b.e     = ib.E_in;
    b.sti   = ib.sti;
    return b;
  endfunction

  function automatic exp_t dut_out();
    exp_t r;
    r.mag  = ob.mag_out;
    r.sign = ob.sign_out;
    r.zero = ob.zero_out;
    r.sah  = ob.S_A_H_out;
    r.sbh  = ob.S_B_H_out;
    r.sch  = ob.S_C_H_out;
    r.cont = ob.cont_out;
    r.d    = ob.d_out;
    r.e    = ob.E_out;
    r.sti  = ob.sti_out;
`ifdef MAF_T4_LZC_EN
    r.lzc  = ob.lzc_out;
`else
    r.lzc  = 7'd0;
`endif
    return r;
  endfunction

  function automatic beat_t mk(input logic [47:0] c,
                               input logic [47:0] s,
                               input logic [73:0] shr,
                               input logic sa, input logic sb,
                               input logic sc,
                               input logic [11:0] e);
    beat_t b;
    b.carry = c;
    b.sum   = s;
    b.shr   = shr;
    b.sa    = sa;
    b.sb    = sb;
    b.sc    = sc;
    b.sah   = e[0];
    b.sbh   = e[1];
    b.sch   = e[2];
    b.cont  = e[2:0] ^ 3'd3;
    b.d     = e + 12'd100;
    b.e     = e;
    b.sti   = e[3:0];
    return b;
  endfunction

  task automatic drive(input beat_t b);
    ib.Carry_in      = b.carry;
    ib.Sum_in        = b.sum;
    ib.sh_rev_reg_in = b.shr;
    ib.S_A           = b.sa;
    ib.S_B           = b.sb;
    ib.S_C           = b.sc;
    ib.S_A_H         = b.sah;
    ib.S_B_H         = b.sbh;
    ib.S_C_H         = b.sch;
    ib.cont_in       = b.cont;
    ib.d_in          = b.d;
    ib.E_in          = b.e;
    ib.sti           = b.sti;
  endtask

  // returns #1 after the accepting edge
  task automatic send(input beat_t b);
    int n;
    n = 0;
    drive(b);
    ib.in_valid = 1'b1;
    @(negedge clk);
    while (!ib.in_ready && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (!ib.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=%0b want 1",
               ib.in_ready);
    end
    @(posedge clk);
    #1 ib.in_valid = 1'b0;
  endtask

  task automatic drain_wait(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk(name, 128'(q.size()), 128'd0);
  endtask

  // single compare process against the model queue
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      if (ob.out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_valid", 128'(ob.out_valid), 128'd0);
        end else begin
          chk("stream", 128'(dut_out()), 128'(q[0]));
          if (ob.out_ready) begin
            elog.push_back(ob.E_out);
            void'(q.pop_front());
          end
        end
      end
      if (ib.in_valid && ib.in_ready)
        q.push_back(model(from_bus()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  logic [7:0] pat;
  beat_t      vec[6];

  initial begin
    drive('0);
    ib.in_valid  = 1'b0;
    ob.out_ready = 1'b1;
    pat = 8'b1011_0010;

    @(negedge clk);
    chk("rst_valid", 128'(ob.out_valid), 128'd0);
    chk("rst_ready", 128'(ib.in_ready), 128'd0);
    chk("rst_data", 128'(dut_out()), 128'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 128'(ib.in_ready), 128'd1);
    chk("post_rst_valid", 128'(ob.out_valid), 128'd0);
    @(posedge clk);
    #1;

    send(mk(48'h1, 48'h2, 74'h4, 0, 0, 0, 12'd10));
    @(negedge clk);
    chk("add_valid", 128'(ob.out_valid), 128'd1);
    chk("add_mag", 128'(ob.mag_out), 128'h7);
    chk("add_sign", 128'(ob.sign_out), 128'd0);
    chk("add_zero", 128'(ob.zero_out), 128'd0);
    @(posedge clk);
    #1;

    send(mk(48'h0, 48'h5, 74'h3, 0, 0, 1, 12'd11));
    @(negedge clk);
    chk("sub_p_mag", 128'(ob.mag_out), 128'h2);
    chk("sub_p_sign", 128'(ob.sign_out), 128'd0);
    @(posedge clk);
    #1;

    send(mk(48'h0, 48'h3, 74'h5, 0, 0, 1, 12'd12));
    @(negedge clk);
    chk("sub_a_mag", 128'(ob.mag_out), 128'h2);
    chk("sub_a_sign", 128'(ob.sign_out), 128'd1);
    @(posedge clk);
    #1;

    send(mk(48'h0, 48'h5, 74'h5, 0, 0, 1, 12'd13));
    @(negedge clk);
    chk("cancel_mag", 128'(ob.mag_out), 128'd0);
    chk("cancel_zero", 128'(ob.zero_out), 128'd1);
    chk("cancel_sign", 128'(ob.sign_out), 128'd0);
`ifdef MAF_T4_LZC_EN
    chk("cancel_lzc", 128'(ob.lzc_out), 128'd74);
`endif
    @(posedge clk);
    #1;
    drain_wait("drain_basic");
    elog.delete();

    ob.out_ready = 1'b0;
    fork
      begin
        send(mk(48'h0, 48'h1, 74'h1, 0, 0, 0, 12'd1));
        send(mk(48'h0, 48'h2, 74'h1, 0, 0, 0, 12'd2));
        send(mk(48'h0, 48'h3, 74'h1, 0, 0, 0, 12'd3));
      end
      begin
        repeat (2) @(negedge clk);
        chk("bp_ready_b2", 128'(ib.in_ready), 128'd1);
        @(negedge clk);
        chk("bp_ready_drop", 128'(ib.in_ready), 128'd0);
        @(posedge clk);
        #1 ob.out_ready = 1'b1;
      end
    join
    drain_wait("drain_bp");
    chk("bp_count", 128'(elog.size()), 128'd3);
    if (elog.size() == 3) begin
      chk("bp_order0", 128'(elog[0]), 128'd1);
      chk("bp_order1", 128'(elog[1]), 128'd2);
      chk("bp_order2", 128'(elog[2]), 128'd3);
    end

    vec[0] = mk(48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF,
                74'h1, 1, 1, 0, 12'd21);
    vec[1] = mk(48'h0, 48'h10,
                74'h200_0000_0000_0000_0001, 1, 0, 0, 12'd22);
    vec[2] = mk(48'h8000_0000_0000, 48'h8000_0000_0000,
                74'h5, 0, 1, 1, 12'd23);
    vec[3] = mk(48'h123, 48'h456, 74'h1000, 0, 1, 0, 12'd24);
    vec[4] = mk(48'h0, 48'h0, 74'h0, 1, 1, 1, 12'd25);
    vec[5] = mk(48'h7FF, 48'h801, 74'h1000, 1, 0, 0, 12'd26);
    fork
      begin
        for (int i = 0; i < 6; i++) send(vec[i]);
      end
      begin
        for (int k = 0; k < 16; k++) begin
          @(posedge clk);
          #1 ob.out_ready = pat[k % 8];
        end
        ob.out_ready = 1'b1;
      end
    join
    drain_wait("drain_mix");

    ob.out_ready = 1'b0;
    send(mk(48'h0, 48'h9, 74'h1, 0, 0, 0, 12'd31));
    send(mk(48'h0, 48'hA, 74'h1, 0, 0, 0, 12'd32));
    rst = 1'b1;
    @(negedge clk);
    chk("rst2_valid", 128'(ob.out_valid), 128'd0);
    chk("rst2_ready", 128'(ib.in_ready), 128'd0);
    chk("rst2_data", 128'(dut_out()), 128'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst2_ready_after", 128'(ib.in_ready), 128'd1);
    chk("rst2_valid_after", 128'(ob.out_valid), 128'd0);
    ob.out_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
